// File: rtl/w_tile_controller.sv
// w_tile_controller: sequences weight-tile fetches into rotating buffer banks
// and hands each loaded tile to the input-feature controller.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   start, num_tiles, abort     job control from the layer sequencer
//   ready, done                 idle flag / job-complete pulse
//   w_read, w_valid             weight memory read handshake
//   w_wr_en, w_wr_addr,
//   w_wr_bank, clr_w            weight-buffer write side
//   if_ready, switch, start_if  handoff to the input-feature controller
//   act_bank, tile_idx          active compute bank / tile being fetched
module w_tile_controller #(
    parameter int ROWS   = 16,
    parameter int NBANK  = 2,
    parameter int TILE_W = 8,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              abort,
    input  logic              w_valid,
    input  logic              if_ready,
    output logic              w_read,
    output logic              w_wr_en,
    output logic [RW-1:0]     w_wr_addr,
    output logic [BW-1:0]     w_wr_bank,
    output logic              clr_w,
    output logic              switch,
    output logic              start_if,
    output logic [BW-1:0]     act_bank,
    output logic [TILE_W-1:0] tile_idx,
    output logic              ready,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [RW-1:0]     row_cnt;
    logic [TILE_W-1:0] tiles_left;
    logic [BW-1:0]     fill_bank;
    logic              first;
    logic              done_r;

    logic xfer;
    logic take;
    logic [BW-1:0] fill_next;

    assign w_read    = (state == FETCH);
    assign ready     = (state == IDLE);
    assign xfer      = w_read & w_valid;
    assign w_wr_en   = xfer;
    assign w_wr_addr = row_cnt;
    assign w_wr_bank = fill_bank;
    assign clr_w     = w_read & first;

    // Handoff fires in the same cycle if_ready is seen; abort suppresses it.
    assign take     = (state == WAIT) & if_ready & ~abort;
    assign switch   = take;
    assign start_if = take;
    assign done     = done_r;

    // Explicit wrap so non-power-of-2 bank counts rotate correctly.
    assign fill_next = (fill_bank == BW'(NBANK - 1)) ? '0 : fill_bank + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            tiles_left <= '0;
            tile_idx   <= '0;
            fill_bank  <= '0;
            act_bank   <= '0;
            first      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort && state != IDLE) begin
                // Banks are kept so a later job continues the rotation.
                state      <= IDLE;
                row_cnt    <= '0;
                tiles_left <= '0;
                first      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (num_tiles != '0) begin
                                state      <= FETCH;
                                tiles_left <= num_tiles;
                                tile_idx   <= '0;
                                row_cnt    <= '0;
                                first      <= 1'b1;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        first <= 1'b0;
                        if (xfer) begin
                            if (row_cnt == RW'(ROWS - 1)) begin
                                row_cnt <= '0;
                                state   <= WAIT;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (if_ready) begin
                            act_bank   <= fill_bank;
                            fill_bank  <= fill_next;
                            tiles_left <= tiles_left - 1'b1;
                            if (tiles_left == TILE_W'(1)) begin
                                state  <= IDLE;
                                done_r <= 1'b1;
                            end else begin
                                state    <= FETCH;
                                tile_idx <= tile_idx + 1'b1;
                                first    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        row_cnt    <= '0;
                        tiles_left <= '0;
                        first      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/w_tile_controller.md
Name: w_tile_controller

Overview:
- Parametrised weight-load sequencer for the systolic array.
- Fetches a programmable number of weight tiles, each of ROWS words, into a rotating set of NBANK weight-buffer banks.
- Hands each loaded tile to the input-feature controller with a switch/start_if pulse, then prefetches the next tile into the next bank while the array computes.
- Sits between the top-level layer sequencer (start/ready/done), the weight memory read port, and the input-feature controller.

Parameters:
- ROWS, 16: weight words per tile (≥2).
- NBANK, 2: number of weight-buffer banks (≥2).
- TILE_W, 8: width of the tile-count input.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a job; sampled only in IDLE
- num_tiles  input  TILE_W  tiles in job; latched on accepted start
- abort  input  1  cancel job; return to IDLE
- w_valid  input  1  weight word present; transfer = w_read & w_valid
- if_ready  input  1  input-feature controller can accept a new tile
- w_read  output  1  request weight word
- w_wr_en  output  1  write transferred word into buffer (= w_read & w_valid)
- w_wr_addr  output  $clog2(ROWS)  row address of transferred word
- w_wr_bank  output  $clog2(NBANK)  bank being filled
- clr_w  output  1  one-cycle clear of fill bank at start of each tile fetch
- switch  output  1  one-cycle pulse: fill bank becomes active bank
- start_if  output  1  one-cycle pulse, identical timing to switch
- act_bank  output  $clog2(NBANK)  bank the array is computing from
- tile_idx  output  TILE_W  index of tile currently being fetched
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse at job completion

Behaviour:
- Reset (async, any time): state IDLE; row_cnt, tiles_left, tile_idx, fill bank, act_bank = 0. All pulses and w_read = 0, ready = 1.
- States:
  - IDLE: ready = 1.
    - start & num_tiles≠0 → FETCH; latch tiles_left = num_tiles, tile_idx = 0.
    - start & num_tiles==0 → done pulses next cycle, stay IDLE.
  - FETCH: w_read = 1.
    - clr_w = 1 in first cycle of FETCH for each tile only (registered first-cycle flag set on entry).
    - Each transfer: w_wr_en = 1, w_wr_addr = row_cnt, w_wr_bank = fill bank, then row_cnt++.
    - Transfer with row_cnt==ROWS-1 → row_cnt = 0, go WAIT.
    - No transfer → hold, no counter change.
  - WAIT: w_read = 0.
    - if_ready low → stay.
    - if_ready high → switch = start_if = 1 (combinational, this cycle). Registered updates: act_bank = fill bank, fill bank = (fill bank+1) mod NBANK, tiles_left--.
    - Then tiles_left was 1 → IDLE with done pulse on the IDLE-entry cycle (registered). Otherwise → FETCH with tile_idx++.
- Handoff latency: at least 1 cycle from last transfer to switch (WAIT always visited).
- Bank rotation: fill bank never equals act_bank after the first switch. Bank indices wrap at NBANK, including non-power-of-2 NBANK.
- w_valid outside FETCH is ignored: no write, no count.
- start outside IDLE is ignored; num_tiles is not re-sampled.
- abort (synchronous, priority over all transitions): next cycle IDLE; row_cnt, tiles_left = 0; no switch, no done. act_bank and fill bank retain their values. abort in IDLE has no effect. abort & start together in IDLE: start ignored.
- if_ready high during FETCH has no effect.
- Async rst mid-job: immediate return to reset values. No partial pulse may be extended past reset assertion.
- X-free outputs in all states, including unused state encodings; those go to IDLE.

Test Plan:
- ROWS=4, NBANK=2, num_tiles=1, w_valid=1, if_ready=1 → w_read 4 cycles, addr 0,1,2,3 bank 0, clr_w in first FETCH cycle, switch/start_if 1 cycle later, act_bank=0, done next cycle, ready=1.
- num_tiles=3, if_ready=1, NBANK=3 → fill banks 0,1,2, act_bank sequence 0,1,2, tile_idx 0,1,2, exactly 3 switch pulses, 1 done.
- num_tiles=2, w_valid toggling 1010…, if_ready low 5 cycles after first tile → 8 cycles per tile fetch, addresses still 0..3, WAIT held 5 cycles, switch on first if_ready=1 cycle.
- start with num_tiles=0 → no w_read, done pulse 1 cycle later, ready stays 1. start pulsed during FETCH → no effect on tile count.
- abort at row_cnt=2 of tile 1 of 3 → IDLE next cycle, no switch, no done. New start with num_tiles=1 fetches from row 0 into the bank after the last active bank.
- rst asserted asynchronously mid-WAIT (between clock edges) → outputs at reset values before the next edge, state IDLE.
